// File: rtl/averager_pkg.sv
// averager_pkg: shared default widths and pipeline metadata for the averager datapath.
package averager_pkg;
    localparam int ACC_WIDTH_DEF        = 32;
    localparam int FAST_COUNT_WIDTH_DEF = 13;
    localparam int IDX_W                = 16;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             clr;
    } pipe_meta_t;
endpackage

// File: rtl/averager_accumulator_acc_forward.sv
// acc_forward: youngest-match bypass over accumulator writes not yet visible through the BRAM read port.
module acc_forward
    import averager_pkg::*;
#(
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int BRAM_LATENCY = 2
) (
    input  logic [IDX_W-1:0]                     idx_i,
    input  logic [BRAM_LATENCY:0]                wvalid_i,
    input  logic [BRAM_LATENCY:0][IDX_W-1:0]     widx_i,
    input  logic [BRAM_LATENCY:0][ACC_WIDTH-1:0] wdata_i,
    output logic                                 hit_o,
    output logic [ACC_WIDTH-1:0]                 data_o
);
    // entry 0 is the youngest write, so scanning oldest-first lets it win
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = BRAM_LATENCY; k >= 0; k--) begin
            if (wvalid_i[k] && widx_i[k] == idx_i) begin
                hit_o  = 1'b1;
                data_o = wdata_i[k];
            end
        end
    end
endmodule

// File: rtl/averager_accumulator.sv
// averager_accumulator: read-modify-write summing of ADC samples into an accumulation BRAM,
// copying completed sums to a result BRAM on the last frame of an acquisition.
module averager_accumulator
    import averager_pkg::*;
#(
    parameter int DATA_WIDTH       = 14,
    parameter int ACC_WIDTH        = ACC_WIDTH_DEF,
    parameter int FAST_COUNT_WIDTH = FAST_COUNT_WIDTH_DEF,
    parameter int BRAM_LATENCY     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    input  logic [FAST_COUNT_WIDTH+1:0]  address,
    input  logic                         wen,
    input  logic                         clr_fback,
    output logic [FAST_COUNT_WIDTH+1:0]  acc_raddr,
    input  logic [ACC_WIDTH-1:0]         acc_rdata,
    output logic [FAST_COUNT_WIDTH+1:0]  acc_waddr,
    output logic [ACC_WIDTH-1:0]         acc_wdata,
    output logic                         acc_we,
    output logic [FAST_COUNT_WIDTH+1:0]  res_waddr,
    output logic [ACC_WIDTH-1:0]         res_wdata,
    output logic                         res_we,
    output logic                         frame_done
);
    localparam int L  = BRAM_LATENCY;
    localparam int GW = $clog2(L + 2);
    localparam logic [GW-1:0] LG   = GW'(L);
    localparam logic [GW-1:0] GMAX = GW'(L + 1);

    typedef struct packed {
        logic                 valid;
        logic [IDX_W-1:0]     idx;
        logic [ACC_WIDTH-1:0] data;
    } wr_t;

    pipe_meta_t                  meta_d, sm;
    pipe_meta_t                  meta_q [L];
    logic [DATA_WIDTH-1:0]       data_q [L];
    wr_t                         hist_d;
    wr_t [L:0]                   hist_q;
    logic [L:0]                  fw_valid;
    logic [L:0][IDX_W-1:0]       fw_idx;
    logic [L:0][ACC_WIDTH-1:0]   fw_data;
    logic                        hit;
    logic [ACC_WIDTH-1:0]        fwd, fb, sum;
    logic [DATA_WIDTH-1:0]       sd;
    logic [IDX_W-1:0]            in_idx, last_idx_q;
    logic                        res_we_d, res_we_q, last_wen_q, end_det, frame_done_d, frame_done_q;
    logic [FAST_COUNT_WIDTH-1:0] res_idx_q;
    logic [ACC_WIDTH-1:0]        res_data_q;
    logic [GW-1:0]               gap_d, gap_q;
    logic [L-1:0]                done_d, done_q;

    assign in_idx    = IDX_W'(address[FAST_COUNT_WIDTH+1:2]);
    assign acc_raddr = address;
    assign sm        = meta_q[L-1];
    assign sd        = data_q[L-1];
    assign fb        = sm.clr ? '0 : (hit ? fwd : acc_rdata);
    assign sum       = fb + {{(ACC_WIDTH-DATA_WIDTH){sd[DATA_WIDTH-1]}}, sd};
    assign res_we_d  = sm.valid && sm.last;
    assign acc_we    = hist_q[0].valid;
    assign acc_waddr = {hist_q[0].idx[FAST_COUNT_WIDTH-1:0], 2'b00};
    assign acc_wdata = hist_q[0].data;
    assign res_we    = res_we_q;
    assign res_waddr = {res_idx_q, 2'b00};
    assign res_wdata = res_data_q;
    assign frame_done = frame_done_q;

    acc_forward #(
        .ACC_WIDTH    (ACC_WIDTH),
        .BRAM_LATENCY (L)
    ) u_fwd (
        .idx_i    (sm.idx),
        .wvalid_i (fw_valid),
        .widx_i   (fw_idx),
        .wdata_i  (fw_data),
        .hit_o    (hit),
        .data_o   (fwd)
    );

    // the end of a wen frame is only known when the following sample shows up, so the
    // pulse is scheduled to land one cycle after that frame's final result write
    assign end_det = din_valid && last_wen_q && (!wen || in_idx < last_idx_q);

    always_comb begin
        meta_d       = '{valid: din_valid, idx: in_idx, last: wen, clr: clr_fback};
        hist_d       = '{valid: sm.valid, idx: sm.idx, data: sm.last ? '0 : sum};
        gap_d        = din_valid ? GW'(1) : (gap_q < GMAX ? gap_q + 1'b1 : gap_q);
        done_d       = (done_q >> 1) | ((end_det && gap_q <= LG) ? (L'(1) << (LG - gap_q)) : '0);
        frame_done_d = done_q[0] || (end_det && gap_q > LG);
        for (int k = 0; k <= L; k++) begin
            fw_valid[k] = hist_q[k].valid;
            fw_idx[k]   = hist_q[k].idx;
            fw_data[k]  = hist_q[k].data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                meta_q[k] <= '0;
                data_q[k] <= '0;
            end
            hist_q       <= '0;
            res_we_q     <= 1'b0;
            res_idx_q    <= '0;
            res_data_q   <= '0;
            last_wen_q   <= 1'b0;
            last_idx_q   <= '0;
            gap_q        <= GMAX;
            done_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            meta_q[0] <= meta_d;
            data_q[0] <= din;
            for (int k = 1; k < L; k++) begin
                meta_q[k] <= meta_q[k-1];
                data_q[k] <= data_q[k-1];
            end
            hist_q   <= {hist_q[L-1:0], hist_d};
            res_we_q <= res_we_d;
            if (res_we_d) begin
                res_idx_q  <= sm.idx[FAST_COUNT_WIDTH-1:0];
                res_data_q <= sum;
            end
            if (din_valid) begin
                last_wen_q <= wen;
                last_idx_q <= in_idx;
            end
            gap_q        <= gap_d;
            done_q       <= done_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_averager_accumulator.sv
// tb_averager_accumulator: randomized and directed stimulus against a memory-level model of
// the averaging rules, with external BRAMs modelled around the DUT.
module tb_averager_accumulator;
    localparam int BL = 3;

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] awd;
        logic        w;
        logic [31:0] sum;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [13:0] din;
    logic               din_valid;
    logic [14:0]        address;
    logic               wen;
    logic               clr_fback;
    logic [14:0]        acc_raddr, acc_waddr, res_waddr;
    logic [31:0]        acc_rdata, acc_wdata, res_wdata;
    logic               acc_we, res_we, frame_done;

    logic [31:0] acc_mem [8192] = '{default: 32'd0};
    logic [31:0] res_mem [8192] = '{default: 32'd0};
    logic [31:0] rd_pipe [BL];
    logic [31:0] m_acc [8];
    logic [31:0] m_res [8];
    wr_t         wq [$];
    int          dq [$];
    int          cyc, n_chk, n_fail, p_idx, p_cyc;
    logic        p_wen;

    always #5 clk = ~clk;

    averager_accumulator #(
        .DATA_WIDTH       (14),
        .ACC_WIDTH        (32),
        .FAST_COUNT_WIDTH (13),
        .BRAM_LATENCY     (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .address    (address),
        .wen        (wen),
        .clr_fback  (clr_fback),
        .acc_raddr  (acc_raddr),
        .acc_rdata  (acc_rdata),
        .acc_waddr  (acc_waddr),
        .acc_wdata  (acc_wdata),
        .acc_we     (acc_we),
        .res_waddr  (res_waddr),
        .res_wdata  (res_wdata),
        .res_we     (res_we),
        .frame_done (frame_done)
    );

    // read-first BRAMs: a read sees only writes committed on earlier edges
    always @(posedge clk) begin
        rd_pipe[0] <= acc_mem[acc_raddr[14:2]];
        for (int i = 1; i < BL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (acc_we) acc_mem[acc_waddr[14:2]] <= acc_wdata;
        if (res_we) res_mem[res_waddr[14:2]] <= res_wdata;
    end
    assign acc_rdata = rd_pipe[BL-1];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model(input int idx, input logic w, input logic c, input logic [13:0] d);
        logic [31:0] s;
        wr_t e;
        s = (c ? 32'd0 : m_acc[idx]) + {{18{d[13]}}, d};
        m_acc[idx] = w ? 32'd0 : s;
        if (w) m_res[idx] = s;
        e.due = cyc + 1 + BL;
        e.idx = idx;
        e.awd = w ? 32'd0 : s;
        e.w   = w;
        e.sum = s;
        wq.push_back(e);
        if (p_wen && (!w || idx < p_idx))
            dq.push_back((p_cyc + 2 + BL > cyc + 1) ? p_cyc + 2 + BL : cyc + 1);
        p_wen = w;
        p_idx = idx;
        p_cyc = cyc;
    endtask

    task automatic check_outputs();
        wr_t e;
        logic ed;
        if (wq.size() > 0 && wq[0].due == cyc) begin
            e = wq.pop_front();
            chk("acc_we", 32'(acc_we), 32'd1);
            chk("acc_waddr", 32'(acc_waddr), 32'(e.idx << 2));
            chk("acc_wdata", acc_wdata, e.awd);
            chk("res_we", 32'(res_we), 32'(e.w));
            if (e.w) begin
                chk("res_waddr", 32'(res_waddr), 32'(e.idx << 2));
                chk("res_wdata", res_wdata, e.sum);
            end
        end else begin
            chk("acc_we_idle", 32'(acc_we), 32'd0);
            chk("res_we_idle", 32'(res_we), 32'd0);
        end
        ed = dq.size() > 0 && dq[0] == cyc;
        if (ed) void'(dq.pop_front());
        chk("frame_done", 32'(frame_done), 32'(ed));
    endtask

    task automatic step(input logic v, input int idx, input logic w, input logic c,
                        input logic [13:0] d, input bit m);
        din_valid = v;
        address   = 15'(idx << 2);
        wen       = w;
        clr_fback = c;
        din       = d;
        if (v && m) model(idx, w, c, d);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 14'd0, 1'b1);
    endtask

    // cm = count_max, clr_sel/din_sel 0:constant 1:per-index 2:random, gap_sel 0:none 1:alternate 2:random
    task automatic acq(input int cm, input int nfr, input int clr_sel, input int din_sel,
                       input logic [13:0] dval, input int gap_sel);
        logic [13:0] d;
        logic c;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k <= cm; k++) begin
                if (gap_sel == 2) idle($urandom_range(0, 3));
                d = din_sel == 0 ? dval : (din_sel == 1 ? 14'(k + 1) : 14'($urandom_range(0, 16383)));
                c = clr_sel == 2 ? 1'($urandom_range(0, 1)) : (clr_sel == 1);
                step(1'b1, k, f == nfr - 1, c, d, 1'b1);
                if (gap_sel == 1) idle(1);
            end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; p_wen = 1'b0; p_idx = 0; p_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            m_acc[k] = 32'd0;
            m_res[k] = 32'd0;
        end
        rst_n = 1'b0;
        idle(3);
        chk("rst_acc_waddr", 32'(acc_waddr), 32'd0);
        chk("rst_acc_wdata", acc_wdata, 32'd0);
        chk("rst_res_waddr", 32'(res_waddr), 32'd0);
        chk("rst_res_wdata", res_wdata, 32'd0);
        chk("rst_acc_raddr", 32'(acc_raddr), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // sample in flight when reset hits must never be written
        step(1'b1, 5, 1'b1, 1'b0, 14'd7, 1'b0);
        idle(1);
        rst_n = 1'b0;
        p_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("midrst_acc_wdata", acc_wdata, 32'd0);
            chk("midrst_res_wdata", res_wdata, 32'd0);
            chk("midrst_acc_waddr", 32'(acc_waddr), 32'd0);
        end
        rst_n = 1'b1;
        idle(BL + 4);
        chk("midrst_res_mem", res_mem[5], 32'd0);

        acq(7, 4, 0, 1, 14'd0, 0);
        idle(BL + 3);
        for (int k = 0; k < 8; k++) begin
            chk("avg_res", res_mem[k], 32'(4 * (k + 1)));
            chk("avg_acc", acc_mem[k], 32'd0);
        end

        acq(7, 3, 1, 0, -14'sd5, 0);
        idle(BL + 3);
        for (int k = 0; k < 8; k++) chk("noavg_res", res_mem[k], 32'hFFFF_FFFB);

        acq(0, 10, 0, 0, 14'd1, 0);
        idle(BL + 3);
        chk("short_res", res_mem[0], 32'd10);
        chk("short_acc", acc_mem[0], 32'd0);

        acq(3, 2, 0, 0, 14'd100, 1);
        idle(BL + 3);
        for (int k = 0; k < 4; k++) chk("bubble_res", res_mem[k], 32'd200);

        acq(3, 2, 0, 0, -14'sd8192, 0);
        idle(BL + 3);
        for (int k = 0; k < 4; k++) chk("sext_res", res_mem[k], 32'hFFFF_C000);

        for (int a = 0; a < 6; a++) begin
            acq($urandom_range(0, 7), $urandom_range(2, 4), 2, 2, 14'd0, $urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end
        step(1'b1, 0, 1'b0, 1'b1, 14'd0, 1'b1);
        idle(BL + 4);
        for (int k = 0; k < 8; k++) begin
            chk("rand_res", res_mem[k], m_res[k]);
            chk("rand_acc", acc_mem[k], m_acc[k]);
        end
        chk("writes_pending", 32'(wq.size()), 32'd0);
        chk("done_pending", 32'(dq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/averager_accumulator.md
# averager_accumulator

Read-modify-write accumulation stage that sits directly downstream of `averager_counter`. It consumes the counter's `address`, `wen` and `clr_fback` together with the ADC sample stream. It sums each sample into an accumulation BRAM word per address. On the final frame of an acquisition (`wen`=1), it writes the completed sums to a result BRAM for the AXI side and clears the accumulator for the next acquisition.

## Interface
- `DATA_WIDTH`, 14: signed ADC sample width.
- `ACC_WIDTH`, 32: accumulator/result word width; must be ≥ DATA_WIDTH + SLOW_COUNT_WIDTH.
- `FAST_COUNT_WIDTH`, 13: matches the counter; depth = 2^FAST_COUNT_WIDTH words.
- `BRAM_LATENCY`, 2: read latency of the accumulation BRAM, 1..3.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  DATA_WIDTH  signed sample, two's complement.
- `din_valid`  in  1  sample strobe, same cycle as the counter's `clken_reg`.
- `address`  in  FAST_COUNT_WIDTH+2  byte address from the counter; word index = `address[FAST_COUNT_WIDTH+1:2]`.
- `wen`  in  1  last-frame flag from the counter.
- `clr_fback`  in  1  forces feedback to zero (no averaging).
- `acc_raddr`  out  FAST_COUNT_WIDTH+2  accumulation BRAM read byte address.
- `acc_rdata`  in  ACC_WIDTH  accumulation BRAM read data, BRAM_LATENCY after `acc_raddr`.
- `acc_waddr`  out  FAST_COUNT_WIDTH+2  accumulation BRAM write byte address.
- `acc_wdata`  out  ACC_WIDTH  accumulation write data.
- `acc_we`  out  1  accumulation write enable.
- `res_waddr`  out  FAST_COUNT_WIDTH+2  result BRAM write byte address.
- `res_wdata`  out  ACC_WIDTH  final sum.
- `res_we`  out  1  result write enable.
- `frame_done`  out  1  one-cycle pulse after the last result write of an acquisition.

## Operation
- Stage 0, on `din_valid`:
  - register `din`, word index, `wen` and `clr_fback`;
  - drive `acc_raddr` = `address` combinationally in the same cycle.
- Delay line: a valid/addr/wen/clr shift register of depth BRAM_LATENCY carries the metadata to the sum stage.
- Sum stage:
  - feedback = 0 if clr, else forwarded value if a hit, else `acc_rdata`;
  - sum = feedback + sign-extended `din`, modulo 2^ACC_WIDTH (no saturation).
- Write stage, registered:
  - `acc_we`=1, `acc_waddr` = addr;
  - `acc_wdata` = 0 if the wen flag is set, else sum;
  - if the wen flag is set: `res_we`=1, `res_waddr` = addr, `res_wdata` = sum.
- Forwarding:
  - Compare the sum-stage word index with every in-flight write not yet visible to the BRAM (write stage plus BRAM_LATENCY older entries).
  - On a match, use the youngest matching value. This value is the already-cleared 0 when that entry carried wen.
  - Forwarding guarantees correct results for any `count_max` ≥ 0, including a frame length of 1.
- `frame_done`: pulses one cycle after a result write whose word index equals the last index of that frame. The last index is detected when the next valid sample carries wen=0, or its index is lower than the previous index.

## Timing
- Sample valid at cycle t → `acc_we`/`res_we` at t+BRAM_LATENCY+1; fixed latency, no stalls, no backpressure.
- `din_valid` may be high every cycle; idle cycles insert bubbles and produce no writes.
- Reset values:
  - all `*_we` = 0, all addresses = 0, all data = 0, `frame_done` = 0;
  - delay-line valids cleared.
- Reset mid-operation: in-flight samples are discarded with no writes. BRAM contents are untouched; software or the next `clr_fback` frame recovers.
- `wen` and `clr_fback` are sampled per sample, so a change mid-frame takes effect at that sample exactly.

## Structure
- Package `averager_pkg`: ACC_WIDTH and FAST_COUNT_WIDTH defaults, and a `pipe_meta_t` struct (valid, idx, last, clr).
- One sub-module, `acc_forward`: a hit-compare/select network over the in-flight write window, parameterised by BRAM_LATENCY.
- The BRAMs themselves are external.

## Test plan
- Averaging: count_max=7, 4 frames, din=idx+1, `clr_fback`=0, `wen` on frame 4 → res word k = 4·(k+1); acc words = 0 afterwards; `frame_done` pulses once.
- No averaging: `clr_fback`=1, din=-5 over 3 frames, last frame wen → every res word = -5 (0xFFFFFFFB).
- Short frame/forwarding: count_max=0, BRAM_LATENCY=3, din=1 every cycle for 10 samples, last with wen → res word 0 = 10.
- Bubbles: `din_valid` toggling 1010…, count_max=3, 2 frames of din=100 → res = 200 per word; writes only for valid samples.
- Reset: assert `rst_n`=0 two cycles after a sample → no `acc_we`/`res_we` afterwards; outputs all 0 during reset.
- Sign extension: din=-8192 (DATA_WIDTH=14), 2 frames → res = -16384 in ACC_WIDTH bits.
